// File: rtl/fb_pkg.sv
// Shared framebuffer geometry constants and writer FSM state type.
package fb_pkg;

  localparam int CORDW     = 16;
  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 120;
  localparam int FB_ADDRW  = $clog2(FB_WIDTH * FB_HEIGHT);
  localparam int FB_DATAW  = 4;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StInit,
    StDraw,
    StDone
  } fb_state_e;

endpackage

// File: rtl/fb_rect_fill.sv
// Framebuffer rectangle filler: clips a signed rectangle to the screen and writes one
// pixel per cycle, row-major, through the framebuffer write port.
module fb_rect_fill
  import fb_pkg::*;
#(
  parameter int unsigned SYNC_FRAME = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    frame_sys,
  input  logic signed [CORDW-1:0] x0,
  input  logic signed [CORDW-1:0] y0,
  input  logic signed [CORDW-1:0] x1,
  input  logic signed [CORDW-1:0] y1,
  input  logic [FB_DATAW-1:0]     colr,
  output logic                    busy,
  output logic                    done,
  output logic                    fb_we,
  output logic [FB_ADDRW-1:0]     fb_addr,
  output logic [FB_DATAW-1:0]     fb_colr
);

  localparam logic signed [CORDW-1:0] XMax       = CORDW'(FB_WIDTH - 1);
  localparam logic signed [CORDW-1:0] YMax       = CORDW'(FB_HEIGHT - 1);
  localparam logic [FB_ADDRW-1:0]     FbWidthA   = FB_ADDRW'(FB_WIDTH);

  fb_state_e state_q, state_d;

  logic signed [CORDW-1:0] x0_q, y0_q, x1_q, y1_q, x0_d, y0_d, x1_d, y1_d;
  logic [FB_DATAW-1:0]     colr_q, colr_d;
  logic [FB_ADDRW-1:0]     xa_q, xb_q, x_q, y_q, yb_q, base_q;
  logic [FB_ADDRW-1:0]     xa_d, xb_d, x_d, y_d, yb_d, base_d;
  logic                    busy_q, busy_d, done_q, done_d, fb_we_q, fb_we_d;
  logic [FB_ADDRW-1:0]     fb_addr_q, fb_addr_d;
  logic [FB_DATAW-1:0]     fb_colr_q, fb_colr_d;

  logic signed [CORDW-1:0] xa_c, xb_c, ya_c, yb_c;
  logic                    empty_c, row_end, last_px;

  // Clip against screen bounds; an off-screen rectangle ends up with a > b.
  always_comb begin
    xa_c    = (x0_q < 0) ? '0 : x0_q;
    ya_c    = (y0_q < 0) ? '0 : y0_q;
    xb_c    = (x1_q > XMax) ? XMax : x1_q;
    yb_c    = (y1_q > YMax) ? YMax : y1_q;
    empty_c = (xa_c > xb_c) || (ya_c > yb_c);
    row_end = (x_q == xb_q);
    last_px = row_end && (y_q == yb_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      x0_q      <= '0;
      y0_q      <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      colr_q    <= '0;
      xa_q      <= '0;
      xb_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      yb_q      <= '0;
      base_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fb_we_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_colr_q <= '0;
    end else begin
      state_q   <= state_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      x1_q      <= x1_d;
      y1_q      <= y1_d;
      colr_q    <= colr_d;
      xa_q      <= xa_d;
      xb_q      <= xb_d;
      x_q       <= x_d;
      y_q       <= y_d;
      yb_q      <= yb_d;
      base_q    <= base_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fb_we_q   <= fb_we_d;
      fb_addr_q <= fb_addr_d;
      fb_colr_q <= fb_colr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = (SYNC_FRAME != 0) ? StWait : StInit;
      StWait:  if (frame_sys) state_d = StInit;
      StInit:  state_d = empty_c ? StDone : StDraw;
      StDraw:  if (last_px) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    x0_d      = x0_q;
    y0_d      = y0_q;
    x1_d      = x1_q;
    y1_d      = y1_q;
    colr_d    = colr_q;
    xa_d      = xa_q;
    xb_d      = xb_q;
    x_d       = x_q;
    y_d       = y_q;
    yb_d      = yb_q;
    base_d    = base_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    fb_we_d   = 1'b0;
    fb_addr_d = fb_addr_q;
    fb_colr_d = fb_colr_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          x0_d   = x0;
          y0_d   = y0;
          x1_d   = x1;
          y1_d   = y1;
          colr_d = colr;
          busy_d = 1'b1;
        end
      end
      StInit: begin
        xa_d   = FB_ADDRW'(xa_c);
        xb_d   = FB_ADDRW'(xb_c);
        x_d    = FB_ADDRW'(xa_c);
        y_d    = FB_ADDRW'(ya_c);
        yb_d   = FB_ADDRW'(yb_c);
        base_d = FB_ADDRW'(ya_c) * FbWidthA;
      end
      StDraw: begin
        fb_we_d   = 1'b1;
        fb_addr_d = base_q + x_q;
        fb_colr_d = colr_q;
        if (row_end) begin
          x_d    = xa_q;
          base_d = base_q + FbWidthA;
          y_d    = y_q + 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      StDone: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign fb_we   = fb_we_q;
  assign fb_addr = fb_addr_q;
  assign fb_colr = fb_colr_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed bench for fb_rect_fill: one free-running instance and one frame-synchronised one.
module tb_fb_rect_fill;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start0 = 1'b0, start1 = 1'b0, frame_sys = 1'b0;
  logic signed [15:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic [3:0]         colr = '0;
  logic               busy0, done0, we0, busy1, done1, we1;
  logic [14:0]        addr0, addr1;
  logic [3:0]         colr0, colr1;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  fb_rect_fill #(.SYNC_FRAME(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .frame_sys(frame_sys),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .colr(colr),
    .busy(busy0), .done(done0), .fb_we(we0), .fb_addr(addr0), .fb_colr(colr0)
  );

  fb_rect_fill #(.SYNC_FRAME(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .frame_sys(frame_sys),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .colr(colr),
    .busy(busy1), .done(done1), .fb_we(we1), .fb_addr(addr1), .fb_colr(colr1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Fill on the free-running instance and compare against exp_q.
  task automatic fill0(input int sx0, input int sy0, input int sx1, input int sy1,
                       input int c, input string tag);
    int idx = 0, cnt = 0, last_we = -1;
    bit ended = 0, gap = 0, seen_done = 0, busy_at_done = 1;
    @(negedge clk);
    x0 = 16'(sx0); y0 = 16'(sy0); x1 = 16'(sx1); y1 = 16'(sy1); colr = 4'(c);
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    x0 = 16'sd3; y0 = 16'sd3; x1 = 16'sd90; y1 = 16'sd90; colr = ~colr;
    chk({tag, " busy after start"}, busy0, 1);
    while (!seen_done && cnt < 300) begin
      @(posedge clk); #1;
      cnt++;
      if (we0) begin
        if (ended) gap = 1;
        if (idx < exp_q.size()) chk($sformatf("%s addr[%0d]", tag, idx), addr0, exp_q[idx]);
        else chk({tag, " extra write"}, idx, exp_q.size());
        chk($sformatf("%s colr[%0d]", tag, idx), colr0, c);
        idx++;
        last_we = cnt;
      end else if (idx > 0) begin
        ended = 1;
      end
      if (done0) begin
        seen_done = 1;
        busy_at_done = busy0;
      end
    end
    chk({tag, " write count"}, idx, exp_q.size());
    chk({tag, " done latency"}, cnt, exp_q.size() + 2);
    chk({tag, " busy low at done"}, busy_at_done, 0);
    chk({tag, " we contiguous"}, gap, 0);
    if (exp_q.size() > 0) chk({tag, " done after last write"}, cnt - last_we, 1);
    @(posedge clk); #1;
    chk({tag, " done one cycle"}, done0, 0);
  endtask

  initial begin
    int any_we, dones, writes;
    int a_seq[$];

    repeat (3) @(posedge clk);
    #1;
    chk("reset busy0", busy0, 0);
    chk("reset done0", done0, 0);
    chk("reset we0", we0, 0);
    chk("reset addr0", addr0, 0);
    chk("reset colr0", colr0, 0);
    chk("reset busy1", busy1, 0);
    rst = 1'b0;

    exp_q = '{3210, 3211, 3212, 3213, 3370, 3371, 3372, 3373};
    fill0(10, 20, 13, 21, 5, "basic");
    exp_q = '{0, 1, 2, 160, 161, 162};
    fill0(-5, -5, 2, 1, 7, "clip_tl");
    exp_q = '{19038, 19039, 19198, 19199};
    fill0(158, 118, 300, 200, 12, "clip_br");
    exp_q = {};
    fill0(50, 10, 40, 20, 3, "empty_x");
    fill0(200, 0, 210, 5, 3, "empty_off");

    // Frame-synchronised instance: nothing may be written before frame_sys.
    @(negedge clk);
    x0 = 16'sd0; y0 = 16'sd0; x1 = 16'sd1; y1 = 16'sd0; colr = 4'd9;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    x0 = 16'sd50; x1 = 16'sd60; colr = 4'd2;
    chk("sync busy after start", busy1, 1);
    any_we = 0; dones = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (we1) any_we++;
      if (done1) dones++;
      start1 = (i % 30 == 10);
    end
    start1 = 1'b0;
    chk("sync no we before frame", any_we, 0);
    chk("sync no done before frame", dones, 0);
    chk("sync busy while waiting", busy1, 1);
    frame_sys = 1'b1;
    writes = 0; dones = 0;
    for (int j = 0; j < 30; j++) begin
      @(posedge clk); #1;
      frame_sys = 1'b0;
      start1 = (j == 1 || j == 2);
      if (we1) begin
        writes++;
        a_seq.push_back(int'(addr1));
        chk("sync colr", colr1, 9);
      end
      if (done1) dones++;
    end
    start1 = 1'b0;
    chk("sync writes", writes, 2);
    chk("sync dones", dones, 1);
    if (a_seq.size() == 2) begin
      chk("sync addr0", a_seq[0], 0);
      chk("sync addr1", a_seq[1], 1);
    end
    chk("sync idle after", busy1, 0);

    // Reset in the middle of a full-screen fill.
    @(negedge clk);
    x0 = 16'sd0; y0 = 16'sd0; x1 = 16'sd159; y1 = 16'sd119; colr = 4'd1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("mid-fill we", we0, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort we", we0, 0);
    chk("abort busy", busy0, 0);
    rst = 1'b0;
    any_we = 0; dones = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (we0) any_we++;
      if (done0) dones++;
    end
    chk("abort no writes", any_we, 0);
    chk("abort no done", dones, 0);
    exp_q = '{0};
    fill0(0, 0, 0, 0, 6, "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
